// File: rtl/mbr_mem_port.sv
// Memory buffer register and memory-side initiator port for the 16-bit datapath.
// Latency: mem_req rises 1 cycle after a start; with zero-wait ready, MBRtoBR/done follow 1 cycle later.
// Backpressure: mem_req is held until mem_ready or timeout; starts outside IDLE are dropped, with no queuing.
module mbr_mem_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control_signal,
    input  logic [ADDR_W-1:0] MARtoMBR,
    input  logic [DATA_W-1:0] ACCtoMBR,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MBRtoBR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // The wait counter is 4 bits wide, so TIMEOUT must lie in 1..15.
    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        WR_REQ = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mbr_q, mbr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic rd_start;
    logic wr_start;
    logic unused_ctrl;

    assign rd_start    = control_signal[3];
    assign wr_start    = control_signal[4];
    assign unused_ctrl = ^{control_signal[31:5], control_signal[2:0]};

    // Next-state and next-output logic; every output is registered from these _d values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mbr_d   = mbr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = req_q;
        we_d    = we_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                // A write beats a simultaneous read; the read is silently dropped.
                if (wr_start) begin
                    state_d = WR_REQ;
                    addr_d  = MARtoMBR;
                    mbr_d   = ACCtoMBR;
                    wdata_d = ACCtoMBR;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end else if (rd_start) begin
                    state_d = RD_REQ;
                    addr_d  = MARtoMBR;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            RD_REQ, WR_REQ: begin
                // Ready is checked first so a completion on the timeout cycle still succeeds.
                if (mem_ready) begin
                    if (state_q == RD_REQ) begin
                        mbr_d = mem_rdata;
                    end
                    state_d = FINISH;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FINISH;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mbr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mbr_q   <= mbr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign MBRtoBR   = mbr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mbr_mem_port.sv
// Directed self-checking bench for mbr_mem_port.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: mem_ready is driven per test to model wait states and timeouts.
module tb_mbr_mem_port;

    localparam logic [31:0] RD = 32'h0000_0008;
    localparam logic [31:0] WR = 32'h0000_0010;

    logic        clk;
    logic        rst;
    logic [31:0] control_signal;
    logic [7:0]  MARtoMBR;
    logic [15:0] ACCtoMBR;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] MBRtoBR;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;

    mbr_mem_port #(.DATA_W(16), .ADDR_W(8), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (control_signal),
        .MARtoMBR       (MARtoMBR),
        .ACCtoMBR       (ACCtoMBR),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .MBRtoBR        (MBRtoBR),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        control_signal = RD;
        MARtoMBR       = 8'h99;
        ACCtoMBR       = 16'h5555;
        mem_rdata      = 16'hAAAA;
        mem_ready      = 1'b1;

        // Reset held with a start and ready asserted.
        tick();
        tick();
        check_eq("rst_req",   mem_req,   0);
        check_eq("rst_we",    mem_we,    0);
        check_eq("rst_busy",  busy,      0);
        check_eq("rst_done",  done,      0);
        check_eq("rst_err",   err,       0);
        check_eq("rst_mbr",   MBRtoBR,   0);
        check_eq("rst_addr",  mem_addr,  0);
        check_eq("rst_wdata", mem_wdata, 0);

        rst            = 1'b1;
        control_signal = 32'h0;
        mem_ready      = 1'b0;
        tick();
        tick();
        check_eq("post_rst_req",  mem_req, 0);
        check_eq("post_rst_busy", busy,    0);
        check_eq("post_rst_done", done,    0);

        // Zero-wait read.
        MARtoMBR       = 8'h2A;
        control_signal = RD | 32'hFFFF_FFE7;
        tick();
        control_signal = 32'h0;
        check_eq("rd_req",  mem_req,  1);
        check_eq("rd_we",   mem_we,   0);
        check_eq("rd_addr", mem_addr, 8'h2A);
        check_eq("rd_busy", busy,     1);
        check_eq("rd_done0", done,    0);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ready = 1'b0;
        check_eq("rd_req_drop", mem_req, 0);
        check_eq("rd_mbr",      MBRtoBR, 16'hBEEF);
        check_eq("rd_done",     done,    1);
        check_eq("rd_busy_end", busy,    0);
        check_eq("rd_err",      err,     0);
        mem_ready = 1'b1;
        tick();
        check_eq("rd_done_once", done, 0);
        tick();
        mem_ready = 1'b0;
        check_eq("idle_ready_ignored", mem_req, 0);

        // Write with three wait cycles.
        ACCtoMBR       = 16'h1234;
        MARtoMBR       = 8'h05;
        control_signal = WR;
        tick();
        control_signal = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_eq("wr_req",   mem_req,   1);
            check_eq("wr_we",    mem_we,    1);
            check_eq("wr_wdata", mem_wdata, 16'h1234);
            check_eq("wr_addr",  mem_addr,  8'h05);
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        check_eq("wr_req_drop", mem_req, 0);
        check_eq("wr_we_drop",  mem_we,  0);
        check_eq("wr_done",     done,    1);
        check_eq("wr_mbr",      MBRtoBR, 16'h1234);
        tick();
        check_eq("wr_done_once", done, 0);

        // Simultaneous read and write starts, then a read start while busy.
        ACCtoMBR       = 16'h00FF;
        MARtoMBR       = 8'h77;
        control_signal = RD | WR;
        tick();
        control_signal = RD;
        check_eq("both_we",    mem_we,    1);
        check_eq("both_wdata", mem_wdata, 16'h00FF);
        check_eq("both_addr",  mem_addr,  8'h77);
        tick();
        control_signal = 32'h0;
        check_eq("busy_start_we",  mem_we,  1);
        check_eq("busy_start_req", mem_req, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check_eq("both_done", done,    1);
        check_eq("both_mbr",  MBRtoBR, 16'h00FF);
        // A start in FINISH must be ignored.
        control_signal = RD;
        tick();
        control_signal = 32'h0;
        check_eq("finish_start_ignored", mem_req, 0);
        tick();
        check_eq("finish_start_no_req", mem_req, 0);

        // Read timeout: mem_req for exactly 15 cycles.
        MARtoMBR       = 8'h3C;
        mem_rdata      = 16'hDEAD;
        control_signal = RD;
        tick();
        control_signal = 32'h0;
        for (int i = 0; i < 15; i++) begin
            check_eq("to_req_held", mem_req, 1);
            tick();
        end
        check_eq("to_req_drop", mem_req, 0);
        check_eq("to_err",      err,     1);
        check_eq("to_done",     done,    1);
        check_eq("to_busy",     busy,    0);
        check_eq("to_mbr",      MBRtoBR, 16'h00FF);
        tick();
        check_eq("to_err_sticky", err,  1);
        check_eq("to_done_once",  done, 0);
        control_signal = RD;
        tick();
        control_signal = 32'h0;
        check_eq("to_err_clear", err,     0);
        check_eq("to_restart",   mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        tick();
        mem_ready = 1'b0;
        check_eq("to_next_mbr", MBRtoBR, 16'hCAFE);
        tick();

        // Ready arriving on the final wait cycle wins over the timeout.
        MARtoMBR       = 8'h11;
        control_signal = RD;
        tick();
        control_signal = 32'h0;
        for (int i = 0; i < 14; i++) tick();
        check_eq("edge_req_held", mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 16'h1357;
        tick();
        mem_ready = 1'b0;
        check_eq("edge_err",  err,     0);
        check_eq("edge_done", done,    1);
        check_eq("edge_mbr",  MBRtoBR, 16'h1357);
        tick();

        // Reset in the middle of a read.
        MARtoMBR       = 8'h42;
        control_signal = RD;
        tick();
        control_signal = 32'h0;
        tick();
        check_eq("mid_req_before", mem_req, 1);
        rst = 1'b0;
        tick();
        check_eq("mid_rst_req",  mem_req,  0);
        check_eq("mid_rst_busy", busy,     0);
        check_eq("mid_rst_done", done,     0);
        check_eq("mid_rst_mbr",  MBRtoBR,  0);
        check_eq("mid_rst_addr", mem_addr, 0);
        rst = 1'b1;
        tick();
        check_eq("mid_post_done", done,    0);
        check_eq("mid_post_req",  mem_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbr_mem_port.md
Name: mbr_mem_port

Overview:
Memory buffer register (MBR) and memory-side port for the 16-bit CPU datapath. It issues memory read/write transactions under the 32-bit control word, and holds the returned word on MBRtoBR for the buffer register feeding the ALU. It also latches the accumulator result and writes it back to memory. This is the producer end of the MBR→BR interface and the initiator end of the memory handshake.

Parameters:
DATA_W, 16, data width of MBR, memory data and ACC.
ADDR_W, 8, memory address width (sourced from MAR).
TIMEOUT, 15, max cycles waiting for mem_ready before abort (4-bit counter range, must be ≥1).

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  synchronous active-low reset, sampled on posedge clk.
control_signal  input  32  control word; bit 3 = RD_START, bit 4 = WR_START; other bits ignored.
MARtoMBR  input  ADDR_W  transaction address, latched at start.
ACCtoMBR  input  DATA_W  store data, latched at WR_START acceptance.
mem_rdata  input  DATA_W  read data from memory, valid when mem_ready=1.
mem_ready  input  1  memory completion strobe.
mem_req  output  1  transaction request, held until ready or timeout.
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
mem_addr  output  ADDR_W  latched address.
mem_wdata  output  DATA_W  latched store data.
MBRtoBR  output  DATA_W  MBR contents to BR.
busy  output  1  transaction in progress.
done  output  1  one-cycle completion pulse.
err  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. MBRtoBR, mem_addr, mem_wdata=0. mem_req, mem_we, busy, done, err=0. Timeout counter=0. Reset overrides any state, including mid-transaction; mem_req drops on that edge.
- States: IDLE, RD_REQ, WR_REQ, FINISH.
- IDLE, WR_START=1: latch MARtoMBR→mem_addr and ACCtoMBR→mbr and mem_wdata. Next state WR_REQ; mem_req=1, mem_we=1, busy=1, err cleared.
- IDLE, RD_START=1, WR_START=0: latch address. Next state RD_REQ; mem_req=1, mem_we=0, busy=1, err cleared.
- RD_START and WR_START both set in IDLE: the write wins and the read is dropped with no error.
- Starts while not in IDLE are ignored; there is no queuing.
- RD_REQ, mem_ready=1: mbr←mem_rdata, so MBRtoBR updates at that edge. Next state FINISH; mem_req=0.
- WR_REQ, mem_ready=1: next state FINISH; mem_req=0, mem_we=0. MBRtoBR keeps the stored value.
- Counter: while in RD_REQ/WR_REQ with mem_ready=0, it increments each cycle. When it reaches TIMEOUT, next state is FINISH, err=1, mem_req=0, and mbr is unchanged. A mem_ready arriving on the same cycle as the timeout wins, with no err. The counter clears on entering any REQ state.
- FINISH: done=1 for exactly one cycle, busy=0, next state IDLE. A start seen in FINISH is ignored.
- Minimum read latency, measured from the RD_START edge:
  - mem_req high on cycle 1;
  - with ready in cycle 1, MBRtoBR is valid from cycle 2;
  - done pulses in cycle 2;
  - a new start is accepted in cycle 3.
- mem_ready seen in IDLE/FINISH is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_ready=1 and RD_START=1 → all outputs 0, no mem_req. Release rst → outputs stay 0 until a start is given.
- Read, zero wait: MARtoMBR=8'h2A, RD_START pulse, mem_ready=1 next cycle with mem_rdata=16'hBEEF → mem_req=1/mem_we=0/mem_addr=8'h2A for 1 cycle. MBRtoBR=16'hBEEF and done=1 one cycle later; err=0.
- Write with 3 wait cycles: ACCtoMBR=16'h1234, MARtoMBR=8'h05, WR_START → mem_we=1, mem_wdata=16'h1234 held for 4 cycles until ready. MBRtoBR=16'h1234, done pulses once.
- Simultaneous RD_START+WR_START with ACCtoMBR=16'h00FF → only a write is issued (mem_we=1). A second RD_START during busy produces no extra transaction.
- Timeout: RD_START, mem_ready held 0 → mem_req drops after TIMEOUT=15 wait cycles, err=1, done pulse, MBRtoBR keeps its prior value. The next RD_START clears err.
- Reset mid-read: rst=0 while in RD_REQ → mem_req=0 and busy=0 on the next edge, no done pulse, MBRtoBR=0.
